// File: rtl/pc_gen_if.sv
// Fetch-PC request/response bundle: decode/execute redirects in, fetch address and RAS status out.
// master = redirect source, slave = pc_gen.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             hold;
    logic             bypass;
    logic             branch;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] PCbranch;
    logic [WIDTH-1:0] PCcurrent;
    logic [WIDTH-1:0] PC;
    logic             misaligned;
    logic             rasEmpty;
    logic             rasFull;
    logic             rasUnderflow;

    modport master (
        output hold, bypass, branch, call, ret, PCbranch, PCcurrent,
        input  PC, misaligned, rasEmpty, rasFull, rasUnderflow
    );

    modport slave (
        input  hold, bypass, branch, call, ret, PCbranch, PCcurrent,
        output PC, misaligned, rasEmpty, rasFull, rasUnderflow
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: bypass > branch > ret > hold > step; circular return-address stack when PC_RAS_EN is defined.
// Latency: every request lands in PC one edge after sampling; no backpressure (hold is the only stall).
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(4),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic     Clock,
    input  logic     nReset,
    pc_gen_if.slave  bus
);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("pc_gen: RAS_DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.misaligned = |pc_q[1:0];

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    top_q;
    logic [PW-1:0]    top_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             under_q;
    logic             under_d;
    logic             push;
    logic [WIDTH-1:0] push_dat;

    always_comb begin
        pc_d     = pc_q + STEP;
        top_d    = top_q;
        cnt_d    = cnt_q;
        under_d  = 1'b0;
        push     = 1'b0;
        push_dat = bus.PCcurrent + STEP;

        if (bus.bypass) begin
            pc_d = bus.PCbranch;
        end else if (bus.branch) begin
            pc_d = bus.PCcurrent + bus.PCbranch;
            if (bus.call) begin
                // Advancing the top pointer on a full stack lands on the oldest slot.
                push  = 1'b1;
                top_d = top_q + PW'(1);
                if (cnt_q != CW'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (bus.ret) begin
            if (cnt_q == '0) begin
                pc_d    = bus.PCbranch;
                under_d = 1'b1;
            end else begin
                pc_d  = ras_q[top_q];
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end else if (bus.hold) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            top_q   <= '0;
            cnt_q   <= '0;
            under_q <= 1'b0;
        end else begin
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            under_q <= under_d;
        end
    end

    // Entry contents are don't-care after reset; only pointer and count are cleared.
    always_ff @(posedge Clock) begin
        if (push) begin
            ras_q[top_d] <= push_dat;
        end
    end

    assign bus.rasEmpty     = (cnt_q == '0);
    assign bus.rasFull      = (cnt_q == CW'(RAS_DEPTH));
    assign bus.rasUnderflow = under_q;
`else
    logic unused_call;
    assign unused_call = bus.call;

    always_comb begin
        pc_d = pc_q + STEP;
        if (bus.bypass) begin
            pc_d = bus.PCbranch;
        end else if (bus.branch) begin
            pc_d = bus.PCcurrent + bus.PCbranch;
        end else if (bus.ret) begin
            pc_d = bus.PCbranch;
        end else if (bus.hold) begin
            pc_d = pc_q;
        end
    end

    assign bus.rasEmpty     = 1'b1;
    assign bus.rasFull      = 1'b0;
    assign bus.rasUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand-written RAS sequences, and a randomized run against a queue-based model.
module tb_pc_gen;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h100),
        .STEP        (32'd4),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .Clock (clk),
        .nReset(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_under;

    typedef struct {
        bit          hold;
        bit          bypass;
        bit          branch;
        bit          call;
        bit          ret;
        logic [31:0] pcb;
        logic [31:0] pcc;
        logic [31:0] exp_pc;
        bit          exp_mis;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit h, input bit byp, input bit br, input bit c, input bit r,
                         input logic [31:0] pcb, input logic [31:0] pcc);
        bus.hold      = h;
        bus.bypass    = byp;
        bus.branch    = br;
        bus.call      = c;
        bus.ret       = r;
        bus.PCbranch  = pcb;
        bus.PCcurrent = pcc;
    endtask

    task automatic model_reset();
        m_pc    = 32'h100;
        m_ras   = {};
        m_under = 1'b0;
    endtask

    // Reference behaviour: the stack is a queue whose back is the top; overflow drops the front.
    task automatic model_step();
        logic [31:0] nxt;
        m_under = 1'b0;
        if (bus.bypass) begin
            nxt = bus.PCbranch;
        end else if (bus.branch) begin
            nxt = bus.PCcurrent + bus.PCbranch;
`ifdef PC_RAS_EN
            if (bus.call) begin
                m_ras.push_back(bus.PCcurrent + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
`endif
        end else if (bus.ret) begin
`ifdef PC_RAS_EN
            if (m_ras.size() > 0) begin
                nxt = m_ras.pop_back();
            end else begin
                nxt     = bus.PCbranch;
                m_under = 1'b1;
            end
`else
            nxt = bus.PCbranch;
`endif
        end else if (bus.hold) begin
            nxt = m_pc;
        end else begin
            nxt = m_pc + 32'd4;
        end
        m_pc = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    bus.PC,                    m_pc);
        check({tag, ".mis"},   {31'd0, bus.misaligned},   {31'd0, m_pc[1:0] != 2'b00});
        check({tag, ".empty"}, {31'd0, bus.rasEmpty},     {31'd0, m_ras.size() == 0});
        check({tag, ".full"},  {31'd0, bus.rasFull},      {31'd0, m_ras.size() == DEPTH});
        check({tag, ".under"}, {31'd0, bus.rasUnderflow}, {31'd0, m_under});
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h104,       0};
        vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h108,       0};
        vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h10C,       0};
        vecs[3]  = '{1, 1, 1, 0, 1, 32'h2000,      32'h0,         32'h2000,      0};
        vecs[4]  = '{1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h2000,      0};
        vecs[5]  = '{0, 0, 1, 0, 0, 32'h80,        32'h40,        32'hC0,        0};
        vecs[6]  = '{0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0};
        vecs[8]  = '{0, 0, 1, 0, 0, 32'h20,        32'hFFFF_FFF0, 32'h10,        0};
        vecs[9]  = '{0, 1, 0, 0, 0, 32'h200,       32'h0,         32'h200,       0};
        vecs[10] = '{1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h200,       0};
        vecs[11] = '{1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h200,       0};
        vecs[12] = '{1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h200,       0};
        vecs[13] = '{0, 1, 0, 0, 0, 32'h202,       32'h0,         32'h202,       1};
        vecs[14] = '{0, 0, 0, 0, 1, 32'h300,       32'h0,         32'h300,       0};
        vecs[15] = '{1, 0, 0, 0, 1, 32'h400,       32'h0,         32'h400,       0};
        vecs[16] = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h404,       0};

        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        model_reset();
        #12;
        check("reset.pc",    bus.PC,                    32'h100);
        check("reset.empty", {31'd0, bus.rasEmpty},     32'd1);
        check("reset.full",  {31'd0, bus.rasFull},      32'd0);
        check("reset.under", {31'd0, bus.rasUnderflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].hold, vecs[i].bypass, vecs[i].branch, vecs[i].call, vecs[i].ret,
                  vecs[i].pcb, vecs[i].pcc);
            tick();
            check($sformatf("vec%0d.pc", i),  bus.PC,                  vecs[i].exp_pc);
            check($sformatf("vec%0d.mis", i), {31'd0, bus.misaligned}, {31'd0, vecs[i].exp_mis});
        end

        // Asynchronous reset in the middle of a cycle with a redirect pending.
        drive(0, 1, 0, 0, 0, 32'h7000, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.pc",    bus.PC,                32'h100);
        check("midrst.empty", {31'd0, bus.rasEmpty}, 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        check("midrst.held", bus.PC, 32'h100);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        check("midrst.step", bus.PC, 32'h104);

        // Call immediately followed by return.
        drive(0, 0, 1, 1, 0, 32'h80, 32'h40);
        tick();
        check("callret.call_pc", bus.PC, 32'hC0);
`ifdef PC_RAS_EN
        check("callret.empty0", {31'd0, bus.rasEmpty}, 32'd0);
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        check("callret.ret_pc", bus.PC, 32'h44);
        check("callret.empty1", {31'd0, bus.rasEmpty}, 32'd1);

        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 1, 0, 32'h0, 32'h10 * k);
            tick();
            check($sformatf("push%0d.pc", k),   bus.PC,               32'h10 * k);
            check($sformatf("push%0d.full", k), {31'd0, bus.rasFull}, {31'd0, k >= 4});
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
            tick();
            check($sformatf("pop%0d.pc", k),    bus.PC,                    32'h54 - 32'h10 * k);
            check($sformatf("pop%0d.under", k), {31'd0, bus.rasUnderflow}, 32'd0);
        end
        check("pops.empty", {31'd0, bus.rasEmpty}, 32'd1);
        drive(0, 0, 0, 0, 1, 32'h900, 32'h0);
        tick();
        check("uflow.pc",    bus.PC,                    32'h900);
        check("uflow.pulse", {31'd0, bus.rasUnderflow}, 32'd1);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        check("uflow.pc2",   bus.PC,                    32'h904);
        check("uflow.clear", {31'd0, bus.rasUnderflow}, 32'd0);
`else
        drive(0, 0, 0, 0, 1, 32'h500, 32'h0);
        tick();
        check("noras.ret_pc", bus.PC,                    32'h500);
        check("noras.empty",  {31'd0, bus.rasEmpty},     32'd1);
        check("noras.under",  {31'd0, bus.rasUnderflow}, 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] pcb;
            r   = int'($urandom_range(0, 99));
            pcb = ($urandom_range(0, 9) == 0) ? $urandom() : {18'd0, 12'($urandom()), 2'b00};
            if ($urandom_range(0, 15) == 0) pcb = 32'hFFFF_FFF8;
            drive(($urandom_range(0, 3) == 0), (r < 8), (r >= 8 && r < 35),
                  ($urandom_range(0, 1) == 1), (r >= 35 && r < 60) || (r < 4),
                  pcb, {20'd0, 10'($urandom()), 2'b00});
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
